alu_bus_sequencer: RTL and testbench
====================================

ALU_BUS_SEQUENCER -- requirements
Module: alu_bus_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 127; max RUN-state cycles without END before abort; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_input  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1; req_ready  out  1  request handshake.
REQ-005 req_op  in  2  00 add, 01 sub, 10 mul, 11 div; req_x  in  16  first operand (div: full dividend); req_y  in  8  second operand / divisor.
REQ-006 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-007 rsp_result  out  16  formatted result; rsp_err  out  1  abort/protocol-error flag.
REQ-008 BEGIN  out  1; op_code  out  2; INBUS  out  8  drive side of the ALU bus.
REQ-009 loadAregister_from_INBUS, loadQregister_from_INBUS, loadMregister_from_INBUS  in  1 each  ALU load strobes.
REQ-010 pushAregister, pushQregister  in  1 each; OUTBUS  in  8; END  in  1  ALU result side.

Function
REQ-011 States: IDLE, START, RUN, RESP; one-hot encoding.
REQ-012 IDLE: req_ready=1; req_valid&req_ready latches req_op/req_x/req_y, goes to START.
REQ-013 START: exactly one cycle; BEGIN=1 only here; goes to RUN unconditionally.
REQ-014 op_code = latched op from START through RESP; 00 in IDLE.
REQ-015 Operand map: add/sub A=x[7:0], M=y; mul Q=x[7:0], M=y; div A=x[15:8], Q=x[7:0], M=y.
REQ-016 INBUS combinational in START/RUN: loadA strobe -> A operand, else loadQ -> Q operand, else loadM -> M operand, else 8'h00; 8'h00 in IDLE/RESP.
REQ-017 Record each load strobe seen in START/RUN; more than one load strobe in the same cycle sets error flag.
REQ-018 Push capture: push strobes registered one cycle; OUTBUS captured into A_res/Q_res in the cycle after the respective strobe (any order).
REQ-019 RUN: timeout counter cleared in START, +1 per RUN cycle; END=1 -> RESP; counter reaching TIMEOUT_CYCLES without END -> RESP with abort.
REQ-020 A capture coinciding with the END cycle SHALL be taken before leaving RUN.
REQ-021 rsp_err=1 if abort, simultaneous load strobes, missing expected load (A for add/sub/div, Q for mul/div, M always), or missing expected push (A always, Q for mul/div).
REQ-022 rsp_result: add/sub {{8{A_res[7]}},A_res}; mul {A_res,Q_res}; div {A_res remainder, Q_res quotient}; 16'h0000 when rsp_err=1.
REQ-023 RESP: rsp_valid=1, rsp_result/rsp_err stable until rsp_ready=1; then IDLE next cycle.
REQ-024 req_ready=0 in START/RUN/RESP; END, load and push strobes outside START/RUN ignored.
REQ-025 Capture registers and flags cleared on entry to START.

Reset
REQ-026 reset_input=1 at any edge, including mid-RUN: state IDLE, BEGIN=0, op_code=00, INBUS=00, rsp_valid=0, rsp_err=0, rsp_result=0000, req_ready=1 after that edge; no partial response emitted.
REQ-027 ALU shares reset_input; no recovery sequence needed after reset.

Verification
REQ-028 Add x=0005, y=03, op 00 -> BEGIN one cycle, INBUS=05 on loadA, 03 on loadM; rsp_result 0008, rsp_err 0.
REQ-029 Sub x=0003, y=05, op 01 -> rsp_result FFFE, rsp_err 0.
REQ-030 Mul x=00FD, y=07, op 10 -> INBUS FD on loadQ, 07 on loadM; pushes A then Q; rsp_result FFEB.
REQ-031 Div x=0064, y=07, op 11 -> INBUS 00/64/07 on loadA/loadQ/loadM; rsp_result 020E.
REQ-032 ALU model never asserts END -> after 127 RUN cycles rsp_valid=1, rsp_err=1, rsp_result 0000; loadA and loadM same cycle -> rsp_err=1.
REQ-033 rsp_ready low 5 cycles -> rsp_valid/result held; reset_input pulse mid-RUN -> IDLE next cycle, req_ready=1, no rsp_valid.

Source files
------------

// File: rtl/alu_bus_sequencer.sv
// alu_bus_sequencer
// Accepts one arithmetic request at a time and sequences it over a shared
// 8-bit ALU bus. It drives BEGIN, op_code and INBUS operands, watches the ALU
// load/push strobes, collects the result bytes from OUTBUS, and presents a
// formatted 16-bit response.
//
// Ports
//   clk, reset_input             clock; synchronous active-high reset
//   req_valid/req_ready          request handshake; req_op, req_x, req_y payload
//   rsp_valid/rsp_ready          response handshake; rsp_result, rsp_err payload
//   BEGIN, op_code, INBUS        drive side of the ALU bus
//   loadAregister_from_INBUS,
//   loadQregister_from_INBUS,
//   loadMregister_from_INBUS     ALU operand load strobes
//   pushAregister, pushQregister ALU result push strobes
//   OUTBUS, END                  ALU result byte and completion flag
module alu_bus_sequencer #(
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic        clk,
    input  logic        reset_input,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_x,
    input  logic [7:0]  req_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        BEGIN,
    output logic [1:0]  op_code,
    output logic [7:0]  INBUS,
    input  logic        loadAregister_from_INBUS,
    input  logic        loadQregister_from_INBUS,
    input  logic        loadMregister_from_INBUS,
    input  logic        pushAregister,
    input  logic        pushQregister,
    input  logic [7:0]  OUTBUS,
    input  logic        END
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        RUN   = 4'b0100,
        RESP  = 4'b1000
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Value of the RUN cycle counter during the last RUN cycle that is allowed
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [1:0]  op_r;
    logic [15:0] x_r;
    logic [7:0]  y_r;
    logic [7:0]  a_res, q_res;
    logic        push_a_d, push_q_d;
    logic        seen_load_a, seen_load_q, seen_load_m;
    logic        got_a, got_q;
    logic        multi_load, abort;
    logic [7:0]  run_count;

    logic        active;
    logic        timeout_hit;
    logic        need_a, need_q;
    logic        err_all;
    logic [7:0]  a_operand, q_operand;
    logic [15:0] formatted;

    assign active      = (state == START) || (state == RUN);
    assign timeout_hit = (run_count == TIMEOUT_LAST);

    // Next-state logic. END has priority over the timeout so a transaction
    // finishing on the very last allowed RUN cycle is not flagged as aborted.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_valid) state_next = START;
            START:   state_next = RUN;
            RUN:     if (END || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand selection and response formatting. Operands that the selected
    // op does not use read as zero. All outputs derive from registered state,
    // so the response stays stable while rsp_ready is low.
    always_comb begin
        a_operand = 8'h00;
        q_operand = 8'h00;
        need_a    = 1'b1;
        need_q    = 1'b0;
        formatted = {{8{a_res[7]}}, a_res};
        unique case (op_r)
            OP_ADD, OP_SUB: begin
                a_operand = x_r[7:0];
            end
            OP_MUL: begin
                q_operand = x_r[7:0];
                need_a    = 1'b0;
                need_q    = 1'b1;
                formatted = {a_res, q_res};
            end
            OP_DIV: begin
                a_operand = x_r[15:8];
                q_operand = x_r[7:0];
                need_q    = 1'b1;
                formatted = {a_res, q_res};
            end
            default: ;
        endcase

        err_all = abort || multi_load || !seen_load_m
               || (need_a && !seen_load_a) || (need_q && !seen_load_q)
               || !got_a || (need_q && !got_q);

        req_ready  = (state == IDLE);
        BEGIN      = (state == START);
        rsp_valid  = (state == RESP);
        rsp_err    = (state == RESP) && err_all;
        rsp_result = ((state == RESP) && !err_all) ? formatted : 16'h0000;
        op_code    = (state == IDLE) ? 2'b00 : op_r;

        INBUS = 8'h00;
        if (active) begin
            if (loadAregister_from_INBUS)      INBUS = a_operand;
            else if (loadQregister_from_INBUS) INBUS = q_operand;
            else if (loadMregister_from_INBUS) INBUS = y_r;
        end
    end

    // State register plus transaction bookkeeping. Everything is cleared on
    // the accepting edge so START begins with a clean slate. Push strobes are
    // delayed one cycle because the ALU presents the byte on OUTBUS the cycle
    // after it pushes; a capture landing on the END cycle is still taken.
    always_ff @(posedge clk) begin
        if (reset_input) begin
            state       <= IDLE;
            op_r        <= 2'b00;
            x_r         <= 16'h0000;
            y_r         <= 8'h00;
            a_res       <= 8'h00;
            q_res       <= 8'h00;
            push_a_d    <= 1'b0;
            push_q_d    <= 1'b0;
            seen_load_a <= 1'b0;
            seen_load_q <= 1'b0;
            seen_load_m <= 1'b0;
            got_a       <= 1'b0;
            got_q       <= 1'b0;
            multi_load  <= 1'b0;
            abort       <= 1'b0;
            run_count   <= 8'h00;
        end else begin
            state <= state_next;

            if (state == IDLE && req_valid) begin
                op_r        <= req_op;
                x_r         <= req_x;
                y_r         <= req_y;
                a_res       <= 8'h00;
                q_res       <= 8'h00;
                push_a_d    <= 1'b0;
                push_q_d    <= 1'b0;
                seen_load_a <= 1'b0;
                seen_load_q <= 1'b0;
                seen_load_m <= 1'b0;
                got_a       <= 1'b0;
                got_q       <= 1'b0;
                multi_load  <= 1'b0;
                abort       <= 1'b0;
                run_count   <= 8'h00;
            end

            if (active) begin
                seen_load_a <= seen_load_a | loadAregister_from_INBUS;
                seen_load_q <= seen_load_q | loadQregister_from_INBUS;
                seen_load_m <= seen_load_m | loadMregister_from_INBUS;
                if ((loadAregister_from_INBUS && loadQregister_from_INBUS)
                    || (loadAregister_from_INBUS && loadMregister_from_INBUS)
                    || (loadQregister_from_INBUS && loadMregister_from_INBUS))
                    multi_load <= 1'b1;

                push_a_d <= pushAregister;
                push_q_d <= pushQregister;
                if (push_a_d) begin
                    a_res <= OUTBUS;
                    got_a <= 1'b1;
                end
                if (push_q_d) begin
                    q_res <= OUTBUS;
                    got_q <= 1'b1;
                end
            end

            if (state == START) begin
                run_count <= 8'h00;
            end else if (state == RUN) begin
                run_count <= run_count + 8'd1;
                if (!END && timeout_hit) abort <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// tb_alu_bus_sequencer
// Directed bench for alu_bus_sequencer. The bench plays the ALU by hand,
// driving the load/push/END strobes cycle by cycle, and compares the bus and
// response outputs against hand-computed values.
module tb_alu_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset_input = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_x = 16'h0000;
    logic [7:0]  req_y = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        BEGIN;
    logic [1:0]  op_code;
    logic [7:0]  INBUS;
    logic        load_a = 1'b0;
    logic        load_q = 1'b0;
    logic        load_m = 1'b0;
    logic        push_a = 1'b0;
    logic        push_q = 1'b0;
    logic [7:0]  OUTBUS = 8'h00;
    logic        END = 1'b0;

    int checks = 0;
    int errors = 0;

    alu_bus_sequencer #(.TIMEOUT_CYCLES(127)) dut (
        .clk                      (clk),
        .reset_input              (reset_input),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_op                   (req_op),
        .req_x                    (req_x),
        .req_y                    (req_y),
        .rsp_valid                (rsp_valid),
        .rsp_ready                (rsp_ready),
        .rsp_result               (rsp_result),
        .rsp_err                  (rsp_err),
        .BEGIN                    (BEGIN),
        .op_code                  (op_code),
        .INBUS                    (INBUS),
        .loadAregister_from_INBUS (load_a),
        .loadQregister_from_INBUS (load_q),
        .loadMregister_from_INBUS (load_m),
        .pushAregister            (push_a),
        .pushQregister            (push_q),
        .OUTBUS                   (OUTBUS),
        .END                      (END)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents a request in IDLE; afterwards the DUT sits in START.
    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] x,
                                 input logic [7:0] y);
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        req_y     = y;
        #1;
        checkOutput("req_ready_idle", {15'd0, req_ready}, 16'd1);
        step();
        req_valid = 1'b0;
        checkOutput("begin_in_start", {15'd0, BEGIN}, 16'd1);
        checkOutput("op_code_start", {14'd0, op_code}, {14'd0, op});
        checkOutput("req_ready_start", {15'd0, req_ready}, 16'd0);
    endtask

    // One ALU-side cycle: drive the strobes, check INBUS, advance one clock.
    task automatic alu_cycle(input logic la, input logic lq, input logic lm,
                             input logic pa, input logic pq, input logic en,
                             input logic [7:0] ob, input logic [7:0] exp_bus,
                             input string tag);
        load_a = la; load_q = lq; load_m = lm;
        push_a = pa; push_q = pq; END = en; OUTBUS = ob;
        #1;
        checkOutput(tag, {8'd0, INBUS}, {8'd0, exp_bus});
        step();
        load_a = 1'b0; load_q = 1'b0; load_m = 1'b0;
        push_a = 1'b0; push_q = 1'b0; END = 1'b0; OUTBUS = 8'h00;
    endtask

    // Checks the response in RESP, then completes the handshake.
    task automatic finish_response(input logic [15:0] exp_result,
                                   input logic exp_err, input logic [1:0] op);
        checkOutput("rsp_valid", {15'd0, rsp_valid}, 16'd1);
        checkOutput("rsp_err", {15'd0, rsp_err}, {15'd0, exp_err});
        checkOutput("rsp_result", rsp_result, exp_result);
        checkOutput("op_code_resp", {14'd0, op_code}, {14'd0, op});
        checkOutput("req_ready_resp", {15'd0, req_ready}, 16'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_done", {15'd0, rsp_valid}, 16'd0);
        checkOutput("req_ready_done", {15'd0, req_ready}, 16'd1);
        checkOutput("op_code_idle", {14'd0, op_code}, 16'd0);
    endtask

    initial begin
        // Reset state
        reset_input = 1'b1;
        step();
        step();
        reset_input = 1'b0;
        checkOutput("reset_req_ready", {15'd0, req_ready}, 16'd1);
        checkOutput("reset_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        checkOutput("reset_begin", {15'd0, BEGIN}, 16'd0);
        checkOutput("reset_rsp_result", rsp_result, 16'h0000);
        alu_cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, "idle_inbus_ignored");

        // Add 0005 + 03, A capture lands on the END cycle
        applyStimulus(2'b00, 16'h0005, 8'h03);
        alu_cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h05, "add_inbus_a");
        checkOutput("begin_low_run", {15'd0, BEGIN}, 16'd0);
        alu_cycle(0, 0, 1, 0, 0, 0, 8'h00, 8'h03, "add_inbus_m");
        alu_cycle(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "add_push_a");
        alu_cycle(0, 0, 0, 0, 0, 1, 8'h08, 8'h00, "add_end");
        finish_response(16'h0008, 1'b0, 2'b00);

        // Sub 0003 - 05 = -2
        applyStimulus(2'b01, 16'h0003, 8'h05);
        alu_cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h03, "sub_inbus_a");
        alu_cycle(0, 0, 1, 0, 0, 0, 8'h00, 8'h05, "sub_inbus_m");
        alu_cycle(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "sub_push_a");
        alu_cycle(0, 0, 0, 0, 0, 0, 8'hFE, 8'h00, "sub_outbus_a");
        alu_cycle(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, "sub_end");
        finish_response(16'hFFFE, 1'b0, 2'b01);

        // Mul FD * 07 = -21 signed
        applyStimulus(2'b10, 16'h00FD, 8'h07);
        alu_cycle(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, "mul_start_idle_bus");
        alu_cycle(0, 1, 0, 0, 0, 0, 8'h00, 8'hFD, "mul_inbus_q");
        alu_cycle(0, 0, 1, 0, 0, 0, 8'h00, 8'h07, "mul_inbus_m");
        alu_cycle(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "mul_push_a");
        alu_cycle(0, 0, 0, 0, 1, 0, 8'hFF, 8'h00, "mul_push_q");
        alu_cycle(0, 0, 0, 0, 0, 0, 8'hEB, 8'h00, "mul_outbus_q");
        alu_cycle(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, "mul_end");
        finish_response(16'hFFEB, 1'b0, 2'b10);

        // Div 0064 / 07 = 14 rem 2, with response backpressure
        applyStimulus(2'b11, 16'h0064, 8'h07);
        alu_cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, "div_inbus_a");
        alu_cycle(0, 1, 0, 0, 0, 0, 8'h00, 8'h64, "div_inbus_q");
        alu_cycle(0, 0, 1, 0, 0, 0, 8'h00, 8'h07, "div_inbus_m");
        alu_cycle(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "div_push_a");
        alu_cycle(0, 0, 0, 0, 1, 0, 8'h02, 8'h00, "div_push_q");
        alu_cycle(0, 0, 0, 0, 0, 0, 8'h0E, 8'h00, "div_outbus_q");
        alu_cycle(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, "div_end");
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_rsp_valid", {15'd0, rsp_valid}, 16'd1);
            checkOutput("hold_rsp_result", rsp_result, 16'h020E);
            step();
        end
        finish_response(16'h020E, 1'b0, 2'b11);

        // Timeout: END never arrives, RESP after exactly 127 RUN cycles
        applyStimulus(2'b00, 16'h0005, 8'h03);
        alu_cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h05, "to_inbus_a");
        alu_cycle(0, 0, 1, 0, 0, 0, 8'h00, 8'h03, "to_inbus_m");
        alu_cycle(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "to_push_a");
        alu_cycle(0, 0, 0, 0, 0, 0, 8'h08, 8'h00, "to_outbus_a");
        for (int i = 0; i < 123; i++) step();
        checkOutput("to_still_run", {15'd0, rsp_valid}, 16'd0);
        step();
        finish_response(16'h0000, 1'b1, 2'b00);

        // Simultaneous loadA and loadM
        applyStimulus(2'b00, 16'h0005, 8'h03);
        alu_cycle(1, 0, 1, 0, 0, 0, 8'h00, 8'h05, "dual_load_inbus");
        alu_cycle(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "dual_push_a");
        alu_cycle(0, 0, 0, 0, 0, 1, 8'h08, 8'h00, "dual_end");
        finish_response(16'h0000, 1'b1, 2'b00);

        // Mul without the Q push
        applyStimulus(2'b10, 16'h00FD, 8'h07);
        alu_cycle(0, 1, 0, 0, 0, 0, 8'h00, 8'hFD, "noq_inbus_q");
        alu_cycle(0, 0, 1, 0, 0, 0, 8'h00, 8'h07, "noq_inbus_m");
        alu_cycle(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, "noq_push_a");
        alu_cycle(0, 0, 0, 0, 0, 1, 8'hFF, 8'h00, "noq_end");
        finish_response(16'h0000, 1'b1, 2'b10);

        // Reset pulse in the middle of RUN
        applyStimulus(2'b00, 16'h0005, 8'h03);
        alu_cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h05, "rst_inbus_a");
        alu_cycle(0, 0, 1, 0, 0, 0, 8'h00, 8'h03, "rst_inbus_m");
        reset_input = 1'b1;
        step();
        reset_input = 1'b0;
        checkOutput("midrst_req_ready", {15'd0, req_ready}, 16'd1);
        checkOutput("midrst_begin", {15'd0, BEGIN}, 16'd0);
        checkOutput("midrst_op_code", {14'd0, op_code}, 16'd0);
        checkOutput("midrst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        checkOutput("midrst_rsp_err", {15'd0, rsp_err}, 16'd0);
        checkOutput("midrst_rsp_result", rsp_result, 16'h0000);
        alu_cycle(1, 0, 0, 1, 0, 1, 8'h08, 8'h00, "midrst_inbus");
        checkOutput("midrst_no_rsp", {15'd0, rsp_valid}, 16'd0);
        checkOutput("midrst_still_idle", {15'd0, req_ready}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
